// File: rtl/bp_be_trace_resp_buffer_if.sv
// Valid/ready response bundle between D$ response ports
// and trace-replay consumers, one lane per channel.
interface bp_be_trace_resp_buffer_if #(
  parameter int num_chan_p = 1,
  parameter int width_p    = 64
);
  logic [num_chan_p-1:0]         v_i;
  logic [num_chan_p*width_p-1:0] data_i;
  logic [num_chan_p-1:0]         ready_o;
  logic [num_chan_p-1:0]         v_o;
  logic [num_chan_p*width_p-1:0] data_o;
  logic [num_chan_p-1:0]         yumi_i;

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o
  );

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o
  );
endinterface

// File: rtl/bp_be_trace_resp_buffer.sv
// Per-channel response FIFOs, LFSR stall injection, watchdog and status.
// Define BP_TRACE_RESP_BUF_STATS_EN for hwm_o / beats_o statistics.
module bp_be_trace_resp_buffer #(
  parameter int num_chan_p      = 1,
  parameter int width_p         = 64,
  parameter int els_p           = 8,
  parameter int max_delay_p     = 15,
  parameter int timeout_width_p = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_be_trace_resp_buffer_if.slave bus,
  input  logic                  stall_mode_i,
  input  logic                  seed_v_i,
  input  logic [15:0]           seed_i,
  input  logic [num_chan_p-1:0] done_i,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic                  error_o
`ifdef BP_TRACE_RESP_BUF_STATS_EN
  ,
  output logic [num_chan_p*($clog2(els_p)+1)-1:0] hwm_o,
  output logic [num_chan_p*32-1:0]                beats_o
`endif
);
  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;

  logic [num_chan_p-1:0] enq;
  logic [num_chan_p-1:0] deq;
  logic [num_chan_p-1:0] empty;
  logic [num_chan_p-1:0] err;

  for (genvar i = 0; i < num_chan_p; i++) begin : chan
    logic [width_p-1:0]  mem [els_p];
    logic [ptr_w_lp-1:0] rd_q;
    logic [ptr_w_lp-1:0] wr_q;
    logic [cnt_w_lp-1:0] cnt_q;
    logic [cnt_w_lp-1:0] cnt_d;
    logic [7:0]          stall_q;
    logic [15:0]         lfsr_q;
    logic [15:0]         seed;
    logic                full;
    logic                new_head;

    assign full     = cnt_q == cnt_w_lp'(els_p);
    assign empty[i] = cnt_q == '0;
    assign seed     = seed_i ^ 16'(i);

    assign bus.ready_o[i] = !full;
    assign bus.v_o[i]     = !empty[i] && stall_q == '0;
    assign bus.data_o[i*width_p +: width_p] =
      empty[i] ? '0 : mem[rd_q];

    assign enq[i] = bus.v_i[i] && !full;
    assign deq[i] = bus.yumi_i[i] && bus.v_o[i];
    assign err[i] = (bus.v_i[i] && full)
                 || (bus.yumi_i[i] && !bus.v_o[i]);

    // a fresh head arrives on fill-from-empty or pop with data behind it
    assign new_head = (enq[i] && empty[i])
      || (deq[i] && (cnt_q > cnt_w_lp'(1) || enq[i]));

    assign cnt_d = cnt_q + cnt_w_lp'(enq[i])
                         - cnt_w_lp'(deq[i]);

    always_ff @(posedge clk_i) begin
      if (enq[i])
        mem[wr_q] <= bus.data_i[i*width_p +: width_p];
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        rd_q    <= '0;
        wr_q    <= '0;
        cnt_q   <= '0;
        stall_q <= '0;
        lfsr_q  <= 16'hACE1 ^ 16'(i);
      end else begin
        if (enq[i]) wr_q <= wr_q + ptr_w_lp'(1);
        if (deq[i]) rd_q <= rd_q + ptr_w_lp'(1);
        cnt_q <= cnt_d;
        if (new_head)
          stall_q <= stall_mode_i
            ? 8'(32'(lfsr_q[7:0]) % (max_delay_p + 1))
            : 8'd0;
        else if (stall_q != '0)
          stall_q <= stall_q - 8'd1;
        if (seed_v_i)
          lfsr_q <= (seed == '0) ? 16'hACE1 : seed;
        else
          lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13]
                                 ^ lfsr_q[12] ^ lfsr_q[10]};
      end
    end

`ifdef BP_TRACE_RESP_BUF_STATS_EN
    logic [cnt_w_lp-1:0] hwm_q;
    logic [31:0]         beats_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        hwm_q   <= '0;
        beats_q <= '0;
      end else begin
        if (cnt_d > hwm_q) hwm_q <= cnt_d;
        if (deq[i]) beats_q <= beats_q + 32'd1;
      end
    end

    assign hwm_o[i*cnt_w_lp +: cnt_w_lp] = hwm_q;
    assign beats_o[i*32 +: 32]           = beats_q;
`endif
  end

  logic [timeout_width_p-1:0] wd_q;
  logic [timeout_width_p-1:0] wd_d;
  logic xfer;
  logic pass_set;
  logic tmo_set;

  assign xfer     = |enq || |deq;
  assign pass_set = &done_i && &empty && !timeout_o;

  always_comb begin
    wd_d = wd_q;
    if (xfer || pass_o)
      wd_d = '0;
    else if (!(&wd_q))
      wd_d = wd_q + timeout_width_p'(1);
  end

  // pass wins a same-cycle tie so the two flags never both set
  assign tmo_set = &wd_d && !pass_o && !pass_set;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wd_q      <= '0;
      pass_o    <= 1'b0;
      timeout_o <= 1'b0;
      error_o   <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (pass_set) pass_o    <= 1'b1;
      if (tmo_set)  timeout_o <= 1'b1;
      if (|err)     error_o   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bp_be_trace_resp_buffer.sv
// Directed + randomized bench for bp_be_trace_resp_buffer with a
// queue-based reference model of buffering, flags and watchdog.
module tb_bp_be_trace_resp_buffer;
  localparam int NC = 4;
  localparam int W = 16;
  localparam int ELS = 8;
  localparam int MD = 15;
  localparam int TW = 6;
  localparam int CW = 4;
  localparam int WD_MAX = (1 << TW) - 1;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic stall_mode_i;
  logic seed_v_i;
  logic [15:0] seed_i;
  logic [NC-1:0] done_i;
  logic pass_o;
  logic timeout_o;
  logic error_o;
`ifdef BP_TRACE_RESP_BUF_STATS_EN
  logic [NC*CW-1:0] hwm_o;
  logic [NC*32-1:0] beats_o;
`endif

  bp_be_trace_resp_buffer_if #(
    .num_chan_p(NC), .width_p(W)
  ) bus ();

  bp_be_trace_resp_buffer #(
    .num_chan_p(NC), .width_p(W), .els_p(ELS),
    .max_delay_p(MD), .timeout_width_p(TW)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .bus(bus),
    .stall_mode_i(stall_mode_i),
    .seed_v_i(seed_v_i),
    .seed_i(seed_i),
    .done_i(done_i),
    .pass_o(pass_o),
    .timeout_o(timeout_o),
    .error_o(error_o)
`ifdef BP_TRACE_RESP_BUF_STATS_EN
    ,
    .hwm_o(hwm_o),
    .beats_o(beats_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [NC-1:0] vin;
  logic [NC-1:0] yum;
  logic [W-1:0]  din [NC];
  logic [W-1:0]  q [NC][$];
  int  deqs [NC];
  int  hwm [NC];
  int  age [NC];
  bit  pv [NC];
  bit  py [NC];
  bit  m_err, m_pass, m_to;
  int  idle;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int c = 0; c < NC; c++)
      if (q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      q[c].delete();
      deqs[c] = 0;
      hwm[c] = 0;
      age[c] = 0;
      pv[c] = 1'b0;
      py[c] = 1'b0;
    end
    m_err = 1'b0;
    m_pass = 1'b0;
    m_to = 1'b0;
    idle = 0;
  endtask

  // Called just after a negedge: drive, check, advance model, clock.
  task automatic cycle();
    logic [NC-1:0]   er, ev, mv;
    logic [NC*W-1:0] ed, dpk;
    bit all_e, pc, tc, any, e, d;
    for (int c = 0; c < NC; c++) dpk[c*W +: W] = din[c];
    bus.v_i = vin;
    bus.yumi_i = yum;
    bus.data_i = dpk;
    for (int c = 0; c < NC; c++) begin
      er[c] = q[c].size() < ELS;
      ev[c] = q[c].size() != 0;
      ed[c*W +: W] = ev[c] ? q[c][0] : '0;
    end
    chk("ready_o", bus.ready_o, er);
    chk("data_o", bus.data_o, ed);
    chk("pass_o", pass_o, m_pass);
    chk("timeout_o", timeout_o, m_to);
    chk("error_o", error_o, m_err);
    if (!stall_mode_i) begin
      chk("v_o", bus.v_o, ev);
      mv = ev;
    end else begin
      chk("v_o_when_empty", bus.v_o & ~ev, '0);
      for (int c = 0; c < NC; c++) begin
        if (pv[c] && !py[c])
          chk("v_o_hold", bus.v_o[c], 1'b1);
        if (ev[c] && !bus.v_o[c]) begin
          age[c]++;
          chk("head_delay", age[c] <= MD, 1'b1);
        end
      end
      mv = bus.v_o & ev;
    end
`ifdef BP_TRACE_RESP_BUF_STATS_EN
    for (int c = 0; c < NC; c++) begin
      chk("beats_o", beats_o[c*32 +: 32], deqs[c]);
      chk("hwm_o", hwm_o[c*CW +: CW], hwm[c]);
    end
`endif
    all_e = all_empty();
    pc = (&done_i) && all_e && !m_to;
    any = 1'b0;
    for (int c = 0; c < NC; c++) begin
      e = vin[c] && er[c];
      d = yum[c] && mv[c];
      if ((vin[c] && !er[c]) || (yum[c] && !mv[c]))
        m_err = 1'b1;
      if (d) begin
        void'(q[c].pop_front());
        deqs[c]++;
        age[c] = 0;
      end
      if (e) q[c].push_back(din[c]);
      if (q[c].size() > hwm[c]) hwm[c] = q[c].size();
      any = any | e | d;
      pv[c] = bus.v_o[c];
      py[c] = yum[c];
    end
    if (any || m_pass) idle = 0;
    else if (idle < WD_MAX) idle++;
    tc = (idle == WD_MAX) && !m_pass && !pc;
    if (pc) m_pass = 1'b1;
    if (tc) m_to = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Reset lands mid low-phase so the checks see the async path.
  task automatic do_reset();
    #2 reset_i = 1'b0;
    #1;
    chk("rst_ready_o", bus.ready_o, {NC{1'b1}});
    chk("rst_v_o", bus.v_o, '0);
    chk("rst_data_o", bus.data_o, '0);
    chk("rst_flags", {pass_o, timeout_o, error_o}, '0);
    model_clear();
    vin = '0;
    yum = '0;
    bus.v_i = '0;
    bus.yumi_i = '0;
    stall_mode_i = 1'b0;
    seed_v_i = 1'b0;
    done_i = '0;
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  initial begin
    int n;
    int mind;
    vin = '0;
    yum = '0;
    for (int c = 0; c < NC; c++) din[c] = '0;
    bus.v_i = '0;
    bus.yumi_i = '0;
    bus.data_i = '0;
    stall_mode_i = 1'b0;
    seed_v_i = 1'b0;
    seed_i = '0;
    done_i = '0;
    model_clear();
    @(negedge clk_i);
    do_reset();

    // back-to-back beats with yumi tied high
    yum = 4'b0001;
    vin = 4'b0001;
    din[0] = 16'h0011; cycle();
    din[0] = 16'h0022; cycle();
    din[0] = 16'h0033; cycle();
    vin = '0;
    cycle();
    cycle();
    chk("t1_error", error_o, 1'b1);

    // overflow on channel 1 then drain
    do_reset();
    vin = 4'b0010;
    for (int k = 0; k < 9; k++) begin
      din[1] = W'(16'hA0 + k);
      cycle();
    end
    vin = '0;
    chk("full_ready", bus.ready_o[1], 1'b0);
    cycle();
    chk("ovf_error", error_o, 1'b1);
    yum = 4'b0010;
    repeat (8) cycle();
    yum = '0;
    cycle();
    chk("drained_v", bus.v_o[1], 1'b0);

    // reset with entries buffered, then fresh traffic
    do_reset();
    vin = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      din[2] = W'($urandom);
      cycle();
    end
    vin = '0;
    do_reset();
    repeat (2) cycle();
    vin = 4'b0100;
    din[2] = 16'h5A5A;
    cycle();
    vin = '0;
    cycle();
    chk("post_rst_data", bus.data_o[2*W +: W], 16'h5A5A);

    // random traffic, no stalls, illegal beats allowed
    do_reset();
    for (int k = 0; k < 300; k++) begin
      for (int c = 0; c < NC; c++) begin
        vin[c] = $urandom_range(0, 2) != 0;
        yum[c] = $urandom_range(0, 2) == 0;
        din[c] = W'($urandom);
      end
      done_i = ($urandom_range(0, 7) == 0) ? '1 : '0;
      cycle();
    end

    // random stalls, legal-only traffic
    do_reset();
    stall_mode_i = 1'b1;
    seed_v_i = 1'b1;
    seed_i = 16'h0001;
    cycle();
    seed_v_i = 1'b0;
    n = 0;
    mind = 0;
    while (mind < 64 && n < 4000) begin
      for (int c = 0; c < NC; c++) begin
        vin[c] = (q[c].size() < ELS)
              && ($urandom_range(0, 2) != 0);
        yum[c] = bus.v_o[c] && ($urandom_range(0, 1) != 0);
        din[c] = W'($urandom);
      end
      cycle();
      n++;
      mind = deqs[0];
      for (int c = 1; c < NC; c++)
        if (deqs[c] < mind) mind = deqs[c];
    end
    chk("stall_beats", mind >= 64, 1'b1);
    vin = '0;
    done_i = '1;
    n = 0;
    while (!all_empty() && n < 300) begin
      yum = bus.v_o;
      cycle();
      n++;
    end
    chk("drain_done", all_empty(), 1'b1);
    yum = '0;
    cycle();
    cycle();
    chk("pass_end", pass_o, 1'b1);
    chk("timeout_end", timeout_o, 1'b0);
    chk("error_end", error_o, 1'b0);

    // idle watchdog expiry
    do_reset();
    repeat (62) cycle();
    chk("to_62", timeout_o, 1'b0);
    cycle();
    chk("to_63", timeout_o, 1'b1);
    done_i = '1;
    repeat (3) cycle();
    chk("no_pass", pass_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_be_trace_resp_buffer.md
Name: bp_be_trace_resp_buffer

Overview:
Multi-channel response buffer and test-completion monitor that sits between N D$ response ports and N trace-replay consumers in the BE cache benches. Each channel has a parametrised-depth FIFO. An optional synthesizable LFSR-driven consumer-stall mode stresses output backpressure. A progress-based watchdog and aggregated pass/timeout/error status generalise the single-cache output FIFO and the free-running timeout counter.

Parameters:
num_chan_p, 1, number of independent cache/replay channels (1..16)
width_p, 64, payload width per channel
els_p, 8, FIFO depth per channel (power of 2, >=2)
max_delay_p, 15, maximum random stall cycles per head element (<=255)
timeout_width_p, 16, watchdog counter width

Ports:
clk_i  in  1  clock
reset_i  in  1  reset
v_i  in  num_chan_p  response valid from cache
data_i  in  num_chan_p*width_p  response payload
ready_o  out  num_chan_p  FIFO not full
v_o  out  num_chan_p  head valid to replay
data_o  out  num_chan_p*width_p  head payload
yumi_i  in  num_chan_p  replay consumes head
stall_mode_i  in  1  0=no stalls, 1=random stalls
seed_v_i  in  1  load LFSR seeds
seed_i  in  16  seed value
done_i  in  num_chan_p  per-channel replay done
pass_o  out  1  sticky pass
timeout_o  out  1  sticky watchdog expiry
error_o  out  1  sticky protocol error

Behaviour:
- Reset: reset_i, asynchronous, active-low; clock clk_i. While reset_i=0: FIFOs empty, ready_o all 1, v_o=0, data_o=0, pass_o=timeout_o=error_o=0, stall counters 0, LFSR[i]=16'hACE1^i, watchdog 0. Reset mid-transfer discards all buffered data.
- Enqueue: v_i[i]&ready_o[i] writes data_i at the tail. ready_o[i]=!full[i], registered count only; no full-with-dequeue bypass.
- Dequeue: v_o[i]&yumi_i[i] pops. Minimum latency enqueue->v_o is 1 cycle; no empty bypass. data_o is the head entry, 0 when empty.
- Simultaneous enqueue+dequeue (not full, not empty): count unchanged, both pointers advance. Pointers wrap modulo els_p.
- Stall mode: when a new head appears (empty->nonempty, or pop with remaining entries) and stall_mode_i=1, stall counter loads LFSR[i][7:0] mod (max_delay_p+1). v_o[i]=nonempty&&cnt==0. The counter decrements to 0. Once v_o is asserted it holds until yumi. With stall_mode_i=0 the counter loads 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle. seed_v_i loads seed_i^i (0 coerced to 16'hACE1).
- Watchdog: cleared on any enqueue or dequeue, or when pass_o=1. Otherwise increments and saturates at all-ones; saturation sets timeout_o.
- pass_o: set when &done_i && all FIFOs empty && !timeout_o. pass_o and timeout_o are mutually exclusive; the first to set wins.
- error_o: set on yumi_i[i] while v_o[i]=0, or v_i[i] while ready_o[i]=0 and data is dropped. Offending beats are ignored.
- All sticky flags clear only on reset.

Optional Feature:
BP_TRACE_RESP_BUF_STATS_EN: adds outputs hwm_o (num_chan_p*($clog2(els_p)+1)), the per-channel occupancy high-water mark, and beats_o (num_chan_p*32), a per-channel dequeue count that wraps at 2^32. Both reset to 0 and update in the cycle after the event. Without the macro these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- num_chan_p=1, stall off: enqueue 0x11,0x22,0x33 back-to-back with yumi_i tied 1 -> v_o high cycles 1-3 with data 0x11,0x22,0x33 in order; ready_o stays 1.
- els_p=8, yumi_i=0: 9 enqueue attempts -> ready_o=0 after the 8th; the 9th asserts error_o; drain returns 8 values in order.
- Stall on, seed 0x0001, max_delay_p=15: 64 beats -> every head delay is in 0..15; v_o never drops before yumi; order preserved.
- num_chan_p=4: independent traffic per channel with done_i all 1 and FIFOs drained -> pass_o=1 the next cycle, timeout_o=0.
- timeout_width_p=6, no traffic, done_i=0 -> timeout_o=1 at cycle 63; a later done_i does not set pass_o.
- Assert reset_i low with 3 entries buffered -> v_o=0 and ready_o=1 immediately (async); after reset, no stale data emerges.
